// File: rtl/cbfp_pkg.sv
// cbfp_pkg: shared constants, sample/beat types and helpers for the CBFP block controller
// Ports: none (package). Imported by cbfp_ctrl_if, cbfp_lsc and cbfp_ctrl.
package cbfp_pkg;
    localparam int IN_WIDTH    = 23;
    localparam int DATA_NUM    = 16;
    localparam int BLOCK_BEATS = 4;
    localparam int SHIFT_WIDTH = 5;
    localparam int SHIFT_POLE  = 12;
    localparam int CNT_WIDTH   = $clog2(BLOCK_BEATS);

    typedef logic signed [IN_WIDTH-1:0] sample_t;
    typedef logic [SHIFT_WIDTH-1:0] shamt_t;
    typedef sample_t [DATA_NUM-1:0] beat_t;
    typedef logic [CNT_WIDTH-1:0] cnt_t;

    function automatic shamt_t min_shamt(input shamt_t a, input shamt_t b);
        return (a < b) ? a : b;
    endfunction
endpackage

// File: rtl/cbfp_ctrl_if.sv
// cbfp_ctrl_if: input beat stream and replay stream of the CBFP block controller
// Signals: in_valid/in_ready/in_real/in_imag (beat in), out_valid/out_ready/out_real/out_imag
// (beat replay), shift_amt_re/shift_amt_im/blk_exp/out_first/out_last (block side info).
// Macro CBFP_BYPASS_EN adds the per-block bypass input.
// Modports: master = beat producer / replay consumer, slave = the controller.
interface cbfp_ctrl_if;
    import cbfp_pkg::*;
    logic   in_valid;
    logic   in_ready;
    beat_t  in_real;
    beat_t  in_imag;
`ifdef CBFP_BYPASS_EN
    logic   bypass;
`endif
    logic   out_valid;
    logic   out_ready;
    beat_t  out_real;
    beat_t  out_imag;
    shamt_t shift_amt_re;
    shamt_t shift_amt_im;
    shamt_t blk_exp;
    logic   out_first;
    logic   out_last;

    modport master (
        output in_valid, in_real, in_imag, out_ready,
`ifdef CBFP_BYPASS_EN
        output bypass,
`endif
        input  in_ready, out_valid, out_real, out_imag,
        input  shift_amt_re, shift_amt_im, blk_exp, out_first, out_last
    );

    modport slave (
        input  in_valid, in_real, in_imag, out_ready,
`ifdef CBFP_BYPASS_EN
        input  bypass,
`endif
        output in_ready, out_valid, out_real, out_imag,
        output shift_amt_re, shift_amt_im, blk_exp, out_first, out_last
    );
endinterface

// File: rtl/cbfp_lsc.sv
// cbfp_lsc: combinational leading-sign count (redundant sign bits) of one sample
// Ports: x (sample_t in), lsc (shamt_t out, 0..IN_WIDTH-1; 0 and -1 give IN_WIDTH-1).
module cbfp_lsc
    import cbfp_pkg::*;
(
    input  sample_t x,
    output shamt_t  lsc
);
    logic run;

    // Walk down from just below the sign bit; count stops at the first bit that differs.
    always_comb begin
        lsc = '0;
        run = 1'b1;
        for (int i = IN_WIDTH - 2; i >= 0; i--) begin
            run = run && (x[i] == x[IN_WIDTH-1]);
            lsc = lsc + shamt_t'(run);
        end
    end
endmodule

// File: rtl/cbfp_ctrl.sv
// cbfp_ctrl: ping-pong block buffer that tracks per-plane minimum LSC and replays blocks with shift amounts
// Ports: clk, rst (async active-high), bus (cbfp_ctrl_if.slave: beat input, beat replay,
// shift_amt_re/im, blk_exp, out_first/out_last). Macro CBFP_BYPASS_EN: per-block bypass to SHIFT_POLE.
module cbfp_ctrl
    import cbfp_pkg::*;
(
    input logic        clk,
    input logic        rst,
    cbfp_ctrl_if.slave bus
);
    localparam cnt_t LAST = cnt_t'(BLOCK_BEATS - 1);

    logic [1:0] full;
    logic       wb, rb, acc, xfer;
    cnt_t       wcnt, rcnt;
    shamt_t     run_min_re, run_min_im, beat_min_re, beat_min_im, nxt_re, nxt_im;
    shamt_t     shift_re [2];
    shamt_t     shift_im [2];
    shamt_t     lsc_re [DATA_NUM];
    shamt_t     lsc_im [DATA_NUM];
    beat_t      mem_re [2][BLOCK_BEATS];
    beat_t      mem_im [2][BLOCK_BEATS];

    for (genvar i = 0; i < DATA_NUM; i++) begin : g_lsc
        cbfp_lsc u_re (.x(bus.in_real[i]), .lsc(lsc_re[i]));
        cbfp_lsc u_im (.x(bus.in_imag[i]), .lsc(lsc_im[i]));
    end

    always_comb begin
        beat_min_re = shamt_t'(IN_WIDTH - 1);
        beat_min_im = shamt_t'(IN_WIDTH - 1);
        for (int i = 0; i < DATA_NUM; i++) begin
            beat_min_re = min_shamt(beat_min_re, lsc_re[i]);
            beat_min_im = min_shamt(beat_min_im, lsc_im[i]);
        end
    end

    // Beat 0 restarts the running minimum so a previous block never leaks in.
    assign nxt_re = (wcnt == '0) ? beat_min_re : min_shamt(run_min_re, beat_min_re);
    assign nxt_im = (wcnt == '0) ? beat_min_im : min_shamt(run_min_im, beat_min_im);

    assign bus.in_ready  = !full[wb];
    assign bus.out_valid = full[rb];
    assign acc           = bus.in_valid && bus.in_ready;
    assign xfer          = bus.out_valid && bus.out_ready;

    // acc needs !full[wb] and xfer needs full[rb], so when both fire the banks differ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full       <= '0;
            wb         <= 1'b0;
            rb         <= 1'b0;
            wcnt       <= '0;
            rcnt       <= '0;
            run_min_re <= '0;
            run_min_im <= '0;
            shift_re   <= '{default: '0};
            shift_im   <= '{default: '0};
        end else begin
            if (acc) begin
                run_min_re <= nxt_re;
                run_min_im <= nxt_im;
                wcnt       <= wcnt + 1'b1;
                if (wcnt == LAST) begin
                    shift_re[wb] <= nxt_re;
                    shift_im[wb] <= nxt_im;
                    full[wb]     <= 1'b1;
                    wb           <= ~wb;
                end
            end
            if (xfer) begin
                rcnt <= rcnt + 1'b1;
                if (rcnt == LAST) begin
                    full[rb] <= 1'b0;
                    rb       <= ~rb;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (acc) begin
            mem_re[wb][wcnt] <= bus.in_real;
            mem_im[wb][wcnt] <= bus.in_imag;
        end
    end

    assign bus.out_real  = mem_re[rb][rcnt];
    assign bus.out_imag  = mem_im[rb][rcnt];
    assign bus.out_first = full[rb] && (rcnt == '0);
    assign bus.out_last  = full[rb] && (rcnt == LAST);

`ifdef CBFP_BYPASS_EN
    logic [1:0] byp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            byp <= '0;
        else if (acc && wcnt == '0)
            byp[wb] <= bus.bypass;
    end

    assign bus.shift_amt_re = byp[rb] ? shamt_t'(SHIFT_POLE) : shift_re[rb];
    assign bus.shift_amt_im = byp[rb] ? shamt_t'(SHIFT_POLE) : shift_im[rb];
`else
    assign bus.shift_amt_re = shift_re[rb];
    assign bus.shift_amt_im = shift_im[rb];
`endif
    assign bus.blk_exp = min_shamt(bus.shift_amt_re, bus.shift_amt_im);
endmodule
